// File: rtl/io_pkg.sv
// Shared types and widths for the UART word input port.
package io_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } rx_state_t;

    // FIFO entry: little-endian byte pair as seen by the core.
    typedef struct packed {
        logic [BYTE_W-1:0] hi;
        logic [BYTE_W-1:0] lo;
    } word_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: rx synchroniser, bit-timing counters and framing FSM.
module uart_rx_byte
    import io_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              byte_valid,
    output logic              frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t         state;
    rx_state_t         state_n;
    logic              rx_meta;
    logic              rx_s;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [BYTE_W-1:0] shift;
    logic              sample_c;
    logic              byte_valid_c;
    logic              frame_err_c;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (!rx_s) state_n = START;
            START:   if (cnt == HALF_LAST) state_n = rx_s ? IDLE : DATA;
            DATA:    if (cnt == FULL_LAST && bit_idx == 3'd7) state_n = STOP;
            STOP:    if (cnt == FULL_LAST) state_n = rx_s ? IDLE : WAIT_HI;
            WAIT_HI: if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        sample_c     = 1'b0;
        byte_valid_c = 1'b0;
        frame_err_c  = 1'b0;
        case (state)
            DATA:    sample_c = (cnt == FULL_LAST);
            STOP: begin
                byte_valid_c = (cnt == FULL_LAST) && rx_s;
                frame_err_c  = (cnt == FULL_LAST) && !rx_s;
            end
            default: ;
        endcase
    end

    // Cycle counter restarts on every state change and at each data-bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            if (state != state_n || state == IDLE || state == WAIT_HI || sample_c) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == START) begin
                bit_idx <= '0;
            end else if (sample_c) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (sample_c) begin
                shift <= {rx_s, shift[BYTE_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= byte_valid_c;
            frame_err  <= frame_err_c;
            if (byte_valid_c) begin
                rx_byte <= shift;
            end
        end
    end

endmodule

// File: rtl/uart_word_in_port.sv
// UART word input port: pairs received bytes into 16-bit words and queues them
// in a first-word-fall-through FIFO read by the core.
module uart_word_in_port
    import io_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [WORD_W-1:0]             rdata,
    output logic                          rvalid,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          frame_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [BYTE_W-1:0] rx_byte;
    logic              byte_valid;
    logic              have_lo;
    logic [BYTE_W-1:0] lo_byte;

    word_t             mem   [FIFO_DEPTH];
    word_t             mem_n [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr_n;
    logic [PTR_W-1:0]  rd_ptr_n;
    logic [LVL_W-1:0]  level_n;
    logic              overflow_n;
    logic              push_c;
    logic              pop_c;
    logic              full_c;
    word_t             head_c;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    // Byte assembler: a framing error discards any pending low byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            have_lo <= 1'b0;
            lo_byte <= '0;
        end else if (frame_err) begin
            have_lo <= 1'b0;
        end else if (byte_valid) begin
            have_lo <= !have_lo;
            if (!have_lo) begin
                lo_byte <= rx_byte;
            end
        end
    end

    assign push_c = byte_valid && have_lo;
    assign pop_c  = rd_en && (level != LVL_W'(0));
    assign full_c = (level == LVL_W'(FIFO_DEPTH));

    // Next FIFO contents; a pop on a full FIFO frees the slot the push writes.
    always_comb begin
        mem_n      = mem;
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        level_n    = level;
        overflow_n = overflow;
        if (push_c && (pop_c || !full_c)) begin
            mem_n[wr_ptr] = '{hi: rx_byte, lo: lo_byte};
            wr_ptr_n      = wr_ptr + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_n = rd_ptr + PTR_W'(1);
        end
        if (push_c && !pop_c) begin
            if (full_c) begin
                overflow_n = 1'b1;
            end else begin
                level_n = level + LVL_W'(1);
            end
        end else if (pop_c && !push_c) begin
            level_n = level - LVL_W'(1);
        end
        head_c = (level_n != LVL_W'(0)) ? mem_n[rd_ptr_n] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            rdata    <= '0;
            rvalid   <= 1'b0;
        end else begin
            mem      <= mem_n;
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            level    <= level_n;
            overflow <= overflow_n;
            rdata    <= head_c;
            rvalid   <= (level_n != LVL_W'(0));
        end
    end

endmodule
